// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C SCL bit-rate generator.
package i2c_pkg;

  localparam int DIV_CNT_WIDTH    = 14;
  localparam int BIT_RATE_OFFSET  = 8;
  localparam int STRETCH_TO_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOW       = 2'd1,
    ST_HIGH_WAIT = 2'd2,
    ST_HIGH      = 2'd3
  } scl_state_t;

endpackage

// File: rtl/i2c_bit_rate_gen_sync2.sv
// Two-flop synchronizer for the SCL pad level; resets to 1 (idle bus level).
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i2c_bit_rate_gen.sv
// SCL bit-rate generator: half period = 8 + twbr*4^twps, with clock stretching support.
// Optional stretch timeout when I2C_STRETCH_TIMEOUT_EN is defined.
//
// state      | meaning
// IDLE       | SCL released, waiting for twen & scl_run
// LOW        | SCL driven low for one half period
// HIGH_WAIT  | SCL released, waiting for the synchronized pad to read high
// HIGH       | SCL high for one half period
module i2c_bit_rate_gen
  import i2c_pkg::*;
#(
  parameter int BIT_RATE_CONST_WIDTH = 8,
  parameter int PRESCALER_WIDTH      = 2
) (
  input  logic                            pclk,
  input  logic                            preset,
  input  logic                            twen,
  input  logic [BIT_RATE_CONST_WIDTH-1:0] twbr,
  input  logic [PRESCALER_WIDTH-1:0]      twps,
  input  logic                            scl_run,
  input  logic                            scl_i,
  output logic                            scl_drive_low,
  output logic                            scl_fall_tick,
  output logic                            scl_rise_tick,
  output logic                            scl_mid_low_tick,
  output logic                            scl_mid_high_tick,
  output logic                            bus_clk_busy,
  output logic                            stretch_timeout
);

  localparam logic [DIV_CNT_WIDTH-1:0] CNT_ONE = DIV_CNT_WIDTH'(1);

  scl_state_t               state, state_nxt;
  logic [DIV_CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [DIV_CNT_WIDTH-1:0] half_q, half_nxt;
  logic [DIV_CNT_WIDTH-1:0] half_calc;
  logic                     scl_sync;
  logic                     to_hit;

  sync2 u_scl_sync (
    .clk (pclk),
    .rst (preset),
    .d   (scl_i),
    .q   (scl_sync)
  );

  // 4^twps is a shift by 2*twps
  assign half_calc = DIV_CNT_WIDTH'(BIT_RATE_OFFSET)
                   + (DIV_CNT_WIDTH'(twbr) << {twps, 1'b0});

`ifdef I2C_STRETCH_TIMEOUT_EN
  logic [STRETCH_TO_WIDTH-1:0] to_cnt;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      to_cnt <= '0;
    end else if (state == ST_HIGH_WAIT) begin
      to_cnt <= to_cnt + STRETCH_TO_WIDTH'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  assign to_hit = (state == ST_HIGH_WAIT) && (&to_cnt);
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      half_q <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      half_q <= half_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    half_nxt  = half_q;
    case (state)
      ST_IDLE: begin
        if (twen && scl_run) begin
          state_nxt = ST_LOW;
          cnt_nxt   = half_calc - CNT_ONE;
          half_nxt  = half_calc;
        end
      end
      ST_LOW: begin
        if (cnt == '0) state_nxt = ST_HIGH_WAIT;
        else           cnt_nxt   = cnt - CNT_ONE;
      end
      ST_HIGH_WAIT: begin
        if (to_hit) begin
          state_nxt = ST_IDLE;
        end else if (scl_sync) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = half_q - CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else if (scl_run) begin
          state_nxt = ST_LOW;
          cnt_nxt   = half_calc - CNT_ONE;
          half_nxt  = half_calc;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!twen) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end
  end

  // Pull-down drops in the last LOW cycle so the synchronizer latency overlaps it.
  assign scl_drive_low     = (state == ST_LOW) && (cnt != '0);
  assign scl_fall_tick     = (state == ST_LOW)  && (cnt == half_q - CNT_ONE);
  assign scl_rise_tick     = (state == ST_HIGH) && (cnt == half_q - CNT_ONE);
  assign scl_mid_low_tick  = (state == ST_LOW)  && (cnt == (half_q >> 1));
  assign scl_mid_high_tick = (state == ST_HIGH) && (cnt == (half_q >> 1));
  assign bus_clk_busy      = (state != ST_IDLE);
  assign stretch_timeout   = to_hit;

endmodule
